// File: rtl/spram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spram_fifo
//  Description : Synchronous FIFO built on a single-port storage array. Each
//                cycle the array serves either one write or one read. When
//                both are possible at once, a last-grant register alternates
//                the grant between them. Reads return data one cycle after
//                the grant.
//                Optional build macro SPRAM_FIFO_ERR_EN adds sticky
//                overflow and underflow flags (o_ovf / o_udf).
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_fifo #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_rd_req,
    output logic                  o_rd_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_afull,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int                c_depth   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_ptr_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_afull   = (ADDR_WIDTH+1)'(AFULL_THRESH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_last_wr;   // 1: last grant was a write, 0: a read
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_cand;
    logic                  w_rd_cand;
    logic                  w_wr_grant;
    logic                  w_rd_grant;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    assign w_wr_cand = i_wr_valid && !w_full;
    assign w_rd_cand = i_rd_req   && !w_empty;

    // On a conflict the side that did not win last time is served
    assign w_wr_grant = w_wr_cand && (!w_rd_cand || !r_last_wr);
    assign w_rd_grant = w_rd_cand && (!w_wr_cand ||  r_last_wr);

    // The single array port is addressed by whichever side is granted
    assign w_addr = w_wr_grant ? r_wr_ptr[ADDR_WIDTH-1:0] : r_rd_ptr[ADDR_WIDTH-1:0];

    // Storage array: contents are deliberately left uninitialised
    always_ff @(posedge clk) begin
        if (w_wr_grant) begin
            r_mem[w_addr] <= i_wr_data;
        end
    end

    // Pointers, occupancy, arbitration history and the registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_wr  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_grant;
            if (w_wr_grant) begin
                r_wr_ptr  <= r_wr_ptr + c_ptr_one;
                r_count   <= r_count + c_ptr_one;
                r_last_wr <= 1'b1;
            end else if (w_rd_grant) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_count   <= r_count - c_ptr_one;
                r_last_wr <= 1'b0;
                r_rd_data <= r_mem[w_addr];
            end
        end
    end

`ifdef SPRAM_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    // Sticky error flags: a request against a full or empty FIFO latches until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (i_wr_valid && w_full) begin
                r_ovf <= 1'b1;
            end
            if (i_rd_req && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`else
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

    assign o_wr_ready = w_wr_grant;
    assign o_rd_ready = w_rd_grant;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_afull    = (r_count >= c_afull);
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_spram_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spram_fifo
//  Description : Directed self-checking bench for spram_fifo with
//                ADDR_WIDTH=2, DATA_WIDTH=8, AFULL_THRESH=3.
//                Fill/drain, alternating arbitration, pointer wrap,
//                reset during a read, and the sticky error flags
//                (macro SPRAM_FIFO_ERR_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_fifo;

    localparam int c_aw = 2;
    localparam int c_dw = 8;
    localparam int c_at = 3;
`ifdef SPRAM_FIFO_ERR_EN
    localparam int c_err = 1;
`else
    localparam int c_err = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_wr_valid;
    logic [c_dw-1:0] i_wr_data;
    logic            o_wr_ready;
    logic            i_rd_req;
    logic            o_rd_ready;
    logic            o_rd_valid;
    logic [c_dw-1:0] o_rd_data;
    logic            o_full;
    logic            o_empty;
    logic            o_afull;
    logic [c_aw:0]   o_count;
    logic            o_ovf;
    logic            o_udf;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [c_dw-1:0] model [$];

    always #5 clk = ~clk;

    spram_fifo #(
        .ADDR_WIDTH   (c_aw),
        .DATA_WIDTH   (c_dw),
        .AFULL_THRESH (c_at)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_valid (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .o_wr_ready (o_wr_ready),
        .i_rd_req   (i_rd_req),
        .o_rd_ready (o_rd_ready),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_afull    (o_afull),
        .o_count    (o_count),
        .o_ovf      (o_ovf),
        .o_udf      (o_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [c_dw-1:0] d);
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        #1;
        check("push_wr_ready", 32'(o_wr_ready), 1);
        step();
        i_wr_valid = 1'b0;
        model.push_back(d);
    endtask

    task automatic pop();
        logic [c_dw-1:0] e;
        i_rd_req = 1'b1;
        #1;
        check("pop_rd_ready", 32'(o_rd_ready), 1);
        step();
        i_rd_req = 1'b0;
        e = (model.size() > 0) ? model.pop_front() : '0;
        check("pop_rd_valid", 32'(o_rd_valid), 1);
        check("pop_rd_data", 32'(o_rd_data), 32'(e));
    endtask

    initial begin
        rst_n      = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_rd_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_empty", 32'(o_empty), 1);
        check("rst_full", 32'(o_full), 0);
        check("rst_afull", 32'(o_afull), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_rd_valid", 32'(o_rd_valid), 0);
        check("rst_rd_data", 32'(o_rd_data), 0);
        check("rst_ovf", 32'(o_ovf), 0);
        check("rst_udf", 32'(o_udf), 0);
        i_wr_valid = 1'b1;
        i_rd_req   = 1'b1;
        #1;
        check("rst_wr_ready", 32'(o_wr_ready), 1);
        check("rst_rd_ready", 32'(o_rd_ready), 0);
        i_wr_valid = 1'b0;
        i_rd_req   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fill to full
        push(8'h11);
        push(8'h22);
        check("fill2_afull", 32'(o_afull), 0);
        check("fill2_count", 32'(o_count), 2);
        push(8'h33);
        check("fill3_afull", 32'(o_afull), 1);
        check("fill3_full", 32'(o_full), 0);
        check("fill3_count", 32'(o_count), 3);
        push(8'h44);
        check("fill4_full", 32'(o_full), 1);
        check("fill4_count", 32'(o_count), 4);
        check("fill4_empty", 32'(o_empty), 0);
        i_wr_valid = 1'b1;
        i_wr_data  = 8'h55;
        #1;
        check("full_wr_ready", 32'(o_wr_ready), 0);
        step();
        i_wr_valid = 1'b0;
        check("full_count", 32'(o_count), 4);
        check("full_ovf", 32'(o_ovf), c_err);

        // Drain from full, with one idle cycle to see data held
        pop();
        step();
        check("idle_rd_valid", 32'(o_rd_valid), 0);
        check("idle_rd_data", 32'(o_rd_data), 32'h11);
        pop();
        pop();
        pop();
        step();
        check("drain_empty", 32'(o_empty), 1);
        check("drain_count", 32'(o_count), 0);
        check("drain_afull", 32'(o_afull), 0);
        i_rd_req = 1'b1;
        #1;
        check("empty_rd_ready", 32'(o_rd_ready), 0);
        step();
        i_rd_req = 1'b0;
        check("empty_rd_valid", 32'(o_rd_valid), 0);
        check("empty_count", 32'(o_count), 0);
        check("empty_udf", 32'(o_udf), c_err);
        check("sticky_ovf", 32'(o_ovf), c_err);

        // Simultaneous requests at count=2; last grant was a read
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        pop();
        check("conf_start_count", 32'(o_count), 2);
        i_wr_valid = 1'b1;
        i_rd_req   = 1'b1;
        i_wr_data  = 8'hB0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("conf_wr_ready", 32'(o_wr_ready), ((k % 2) == 0) ? 1 : 0);
            check("conf_rd_ready", 32'(o_rd_ready), ((k % 2) == 1) ? 1 : 0);
            step();
            if ((k % 2) == 0) begin
                model.push_back(i_wr_data);
                i_wr_data = i_wr_data + 8'h01;
                check("conf_wr_count", 32'(o_count), 3);
                check("conf_wr_rd_valid", 32'(o_rd_valid), 0);
            end else begin
                check("conf_rd_count", 32'(o_count), 2);
                check("conf_rd_valid", 32'(o_rd_valid), 1);
                check("conf_rd_data", 32'(o_rd_data), 32'(model.pop_front()));
            end
        end
        i_wr_valid = 1'b0;
        i_rd_req   = 1'b0;
        pop();
        pop();
        check("conf_end_empty", 32'(o_empty), 1);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 10; i++) begin
            push(8'hC0 + 8'(i));
            check("wrap_full", 32'(o_full), 0);
            pop();
        end
        check("wrap_empty", 32'(o_empty), 1);
        check("wrap_ovf", 32'(o_ovf), c_err);
        check("wrap_udf", 32'(o_udf), c_err);

        // Reset asserted while a read is in flight
        push(8'hD0);
        push(8'hD1);
        i_rd_req = 1'b1;
        step();
        check("pre_rst_rd_valid", 32'(o_rd_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rd_valid", 32'(o_rd_valid), 0);
        check("midrst_count", 32'(o_count), 0);
        check("midrst_empty", 32'(o_empty), 1);
        check("midrst_ovf", 32'(o_ovf), 0);
        check("midrst_udf", 32'(o_udf), 0);
        check("midrst_rd_data", 32'(o_rd_data), 0);
        step();
        check("inrst_rd_valid", 32'(o_rd_valid), 0);
        i_rd_req = 1'b0;
        model.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("postrst_rd_valid", 32'(o_rd_valid), 0);
        check("postrst_empty", 32'(o_empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_fifo.md
SPRAM_FIFO -- requirements
Module: spram_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: storage depth is 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 SHALL have parameter AFULL_THRESH, default 2**ADDR_WIDTH-2: occupancy at which o_afull asserts.
REQ-004 SHALL have port clk, input, 1 bit: the only clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_wr_valid, input, 1 bit: write request.
REQ-007 SHALL have port i_wr_data, input, DATA_WIDTH bits: write word.
REQ-008 SHALL have port o_wr_ready, output, 1 bit: write accepted this cycle when high together with i_wr_valid.
REQ-009 SHALL have port i_rd_req, input, 1 bit: read request.
REQ-010 SHALL have port o_rd_ready, output, 1 bit: read accepted this cycle when high together with i_rd_req.
REQ-011 SHALL have port o_rd_valid, output, 1 bit: o_rd_data holds a newly read word this cycle.
REQ-012 SHALL have port o_rd_data, output, DATA_WIDTH bits: read word, registered.
REQ-013 SHALL have ports o_full and o_empty, output, 1 bit each: occupancy equals 2**ADDR_WIDTH, occupancy equals 0.
REQ-014 SHALL have port o_afull, output, 1 bit: occupancy >= AFULL_THRESH.
REQ-015 SHALL have port o_count, output, ADDR_WIDTH+1 bits: current occupancy.
REQ-016 SHALL have ports o_ovf and o_udf, output, 1 bit each: sticky overflow and underflow flags (see REQ-033).

Function
REQ-017 SHALL store data in a single-port array: at most one access, read or write, per clock.
REQ-018 SHALL keep write and read pointers of ADDR_WIDTH+1 bits in binary; the low ADDR_WIDTH bits address the array, and the MSB toggles on wrap.
REQ-019 SHALL assert o_full when the pointer MSBs differ and the low bits are equal, and o_empty when the pointers are equal.
REQ-020 SHALL take a write candidate as i_wr_valid and !o_full, and a read candidate as i_rd_req and !o_empty.
REQ-021 SHALL, when only one candidate exists, grant that candidate.
REQ-022 SHALL, when both candidates exist, grant round-robin using a last-grant register: write if the last grant was a read, otherwise read. After reset the first conflict grants write.
REQ-023 SHALL derive o_wr_ready and o_rd_ready combinationally as the grants; a requester not granted SHALL hold its request and data until it is granted.
REQ-024 SHALL, on a granted write, write i_wr_data at the write pointer and increment it on the same edge.
REQ-025 SHALL, on a granted read, increment the read pointer, then assert o_rd_valid for exactly one cycle on the next cycle with the word in o_rd_data; read latency is 1 cycle.
REQ-026 SHALL hold o_rd_data between reads; o_rd_valid SHALL be 0 in cycles that follow no read grant.
REQ-027 SHALL update o_count as +1 on a write grant and -1 on a read grant; both never occur in the same cycle.
REQ-028 SHALL never write when full or read when empty; the pointers and o_count are unchanged in those cycles.

Reset
REQ-029 SHALL, while rst_n is 0, clear both pointers, o_count, the last-grant register (to "read"), o_rd_valid, o_rd_data, o_ovf and o_udf.
REQ-030 SHALL therefore drive o_empty=1, o_full=0, o_afull=0 (for AFULL_THRESH>0) and both readies combinationally from the cleared state.
REQ-031 SHALL discard a read granted in the cycle reset asserts: no o_rd_valid appears after reset.
REQ-032 SHALL not initialise array contents.

Configuration
REQ-033 SHALL, with macro SPRAM_FIFO_ERR_EN defined, set o_ovf sticky when i_wr_valid and o_full, and set o_udf sticky when i_rd_req and o_empty; both clear only on reset.
REQ-034 SHALL, without SPRAM_FIFO_ERR_EN, tie o_ovf and o_udf to 0 and include no flag registers.

Verification (ADDR_WIDTH=2, DATA_WIDTH=8, AFULL_THRESH=3)
REQ-035 SHALL cover: reset, then write 0x11,0x22,0x33,0x44 -> o_afull after the 3rd write, o_full and o_count=4 after the 4th, a 5th i_wr_valid gets o_wr_ready=0.
REQ-036 SHALL cover: from full, read 4 times -> o_rd_data 0x11,0x22,0x33,0x44 each one cycle after its grant, then o_empty=1 and o_count=0.
REQ-037 SHALL cover: i_wr_valid and i_rd_req held together with count=2 -> grants alternate write/read starting with write, o_count stays in 2..3.
REQ-038 SHALL cover: 10 writes and reads interleaved across pointer wrap -> data order preserved, o_full never asserts.
REQ-039 SHALL cover: rst_n pulsed low mid-read -> o_rd_valid=0, o_count=0, o_empty=1 immediately.
REQ-040 SHALL cover, with SPRAM_FIFO_ERR_EN: write while full -> o_ovf=1 until reset; read while empty -> o_udf=1. Without the macro, both flags stay 0.
